imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
Boot-time sequencer and port arbiter for the RV32I hart's instruction memory. After reset it clears every word and then streams a program image from a loader interface (UART/debug bridge) into memory. It then grants the single memory port to the core's fetch path and releases the core hold. A reload request re-runs the clear/load sequence without a global reset.

Parameters:
DWIDTH, 32, width of the program counter / fetch address
MEM_SIZE, 16384, instruction memory depth in 32-bit words; power of two, at least 4
ADDR_SIZE, $clog2(MEM_SIZE), word address width (localparam, derived)

Ports:
Clk_Core  in  1  core clock; all state on rising edge
Rst_Core  in  1  asynchronous, active-high reset
Reload_Req  in  1  single-cycle pulse; restarts boot sequence (sampled in RUN only)
Load_Valid  in  1  loader word valid
Load_Data  in  32  loader instruction word
Load_Last  in  1  marks final word of image; qualified by Load_Valid
Load_Ready  out  1  controller accepts loader word this cycle
Fetch_Addr  in  DWIDTH  byte PC from fetch stage
Fetch_Misalign  out  1  Fetch_Addr[1:0]!=0 while in RUN
Mem_Addr  out  ADDR_SIZE  word address to instruction memory
Mem_We  out  1  write strobe to instruction memory
Mem_Wdata  out  32  write data to instruction memory
Core_Hold  out  1  holds hart in reset/stall; high outside RUN
Boot_Done  out  1  high in RUN
Load_Error  out  1  sticky: image exceeded MEM_SIZE words
Load_Count  out  ADDR_SIZE+1  number of words written by last load

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clear counter=0, load counter=0, Load_Error=0, Load_Count=0.
- Outputs during reset: Core_Hold=1, Boot_Done=0, Load_Ready=0, Mem_We=0, Fetch_Misalign=0.
- State CLEAR:
  - Mem_We=1, Mem_Wdata=0, Mem_Addr=clear counter. Counter increments each cycle.
  - After writing word MEM_SIZE-1, go to LOAD with load counter=0. Takes exactly MEM_SIZE cycles.
  - Load_Ready=0 throughout.
- State LOAD:
  - Load_Ready=1. A word transfers on Load_Valid&Load_Ready.
  - While load counter<MEM_SIZE, a transfer drives Mem_We=1, Mem_Addr=load counter[ADDR_SIZE-1:0], Mem_Wdata=Load_Data, combinational in the same cycle. The load counter then increments.
  - If load counter==MEM_SIZE when a transfer occurs, the word is dropped (Mem_We=0) and Load_Error is set next cycle.
  - A transfer with Load_Last=1 moves the state to RUN next cycle. Load_Count latches the final counter value, saturated at MEM_SIZE.
  - No Load_Valid means no write and no state change; the controller waits indefinitely.
- State RUN:
  - Mem_We=0, Mem_Addr=Fetch_Addr[ADDR_SIZE+1:2] (combinational). Upper address bits are ignored, so fetches wrap modulo memory size.
  - Core_Hold=0, Boot_Done=1, Load_Ready=0.
  - Fetch_Misalign=|Fetch_Addr[1:0] (combinational, informational only).
  - Reload_Req=1 moves to CLEAR next cycle and clears Load_Error, Load_Count and both counters. Core_Hold rises in that same next cycle.
- Reload_Req is ignored in CLEAR and LOAD.
- Loader words presented in CLEAR or RUN are not accepted (Load_Ready=0); the loader must hold them.
- Reset asserted mid-CLEAR or mid-LOAD aborts immediately. Memory contents are unspecified until the next full sequence; the sequence restarts at CLEAR.
- Empty image: a single transfer with Load_Last=1 is a real word. There is no zero-length image.

Test Plan:
- MEM_SIZE=16, release reset -> Mem_We=1 for 16 consecutive cycles with Mem_Addr 0..15 and Mem_Wdata=0; Load_Ready rises on cycle 17; Core_Hold=1 throughout.
- Load 4 words 0x00500093,0x00A00113,0x002081B3,0x0000006F with Last on 4th; Load_Valid gapped every other cycle -> writes to addrs 0..3 only on handshake cycles; RUN next cycle; Load_Count=4; Core_Hold=0.
- In RUN, Fetch_Addr=0x8 -> Mem_Addr=2, Fetch_Misalign=0; Fetch_Addr=0x46 -> Mem_Addr=1 (wrap), Fetch_Misalign=1; Mem_We=0.
- MEM_SIZE=16, stream 18 words with Last on 18th -> 16 writes at addrs 0..15, words 17-18 dropped, Load_Error=1, Load_Count=16, RUN entered.
- Reload_Req pulse in RUN -> next cycle Core_Hold=1, Boot_Done=0, Load_Error=0, CLEAR writes restart at addr 0; Reload_Req pulsed during LOAD -> no effect.
- Assert Rst_Core asynchronously mid-LOAD after 2 words -> outputs reach reset values without a clock edge; after release, full 16-cycle CLEAR runs again.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot sequencer and single-port arbiter for the hart's
// instruction memory. After reset it zero-fills the memory, then streams a
// program image from the loader into it, then hands the port to the fetch
// path and releases the core hold. A reload request in RUN repeats the
// clear/load sequence.
module imem_boot_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int MEM_SIZE = 16384,
  localparam int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core,
  input  logic                 Reload_Req,
  input  logic                 Load_Valid,
  input  logic [31:0]          Load_Data,
  input  logic                 Load_Last,
  output logic                 Load_Ready,
  input  logic [DWIDTH-1:0]    Fetch_Addr,
  output logic                 Fetch_Misalign,
  output logic [ADDR_SIZE-1:0] Mem_Addr,
  output logic                 Mem_We,
  output logic [31:0]          Mem_Wdata,
  output logic                 Core_Hold,
  output logic                 Boot_Done,
  output logic                 Load_Error,
  output logic [ADDR_SIZE:0]   Load_Count
);

  // Last address written by the clear pass, and the load-counter value that
  // means "memory full" (one past the last word).
  localparam logic [ADDR_SIZE-1:0] LAST_CLEAR_ADDR = ADDR_SIZE'(MEM_SIZE - 1);
  localparam logic [ADDR_SIZE:0]   LOAD_FULL       = (ADDR_SIZE + 1)'(MEM_SIZE);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [ADDR_SIZE-1:0]   clear_cnt_reg;
  logic [ADDR_SIZE:0]     load_cnt_reg;
  logic                   load_error_reg;
  logic [ADDR_SIZE:0]     load_count_reg;

  logic                   load_xfer;
  logic                   load_room;
  logic                   load_wr;
  logic [ADDR_SIZE:0]     load_count_next;

  // Fetch wraps modulo memory size, so the PC bits above the word index are
  // intentionally ignored.
  logic                   unused_fetch_upper;
  assign unused_fetch_upper = ^Fetch_Addr[DWIDTH-1:ADDR_SIZE+2];

  // A loader handshake happens only in LOAD; it writes only while there is room.
  assign load_xfer = (state_reg == ST_LOAD) && Load_Valid;
  assign load_room = (load_cnt_reg != LOAD_FULL);
  assign load_wr   = load_xfer && load_room;

  // Words written by the image, saturating at the memory depth.
  assign load_count_next = load_room ? (load_cnt_reg + 1'b1) : load_cnt_reg;

  // Status outputs are decoded from the state register alone.
  assign Core_Hold      = (state_reg != ST_RUN);
  assign Boot_Done      = (state_reg == ST_RUN);
  assign Load_Ready     = (state_reg == ST_LOAD);
  assign Fetch_Misalign = (state_reg == ST_RUN) && (|Fetch_Addr[1:0]);
  assign Load_Error     = load_error_reg;
  assign Load_Count     = load_count_reg;

  // Memory port mux: clear pass, loader writes, or fetch reads. The clear
  // strobe is gated by reset so no write escapes while reset is held.
  always_comb begin
    Mem_We    = 1'b0;
    Mem_Wdata = 32'd0;
    Mem_Addr  = Fetch_Addr[ADDR_SIZE+1:2];
    case (state_reg)
      ST_CLEAR: begin
        Mem_We   = !Rst_Core;
        Mem_Addr = clear_cnt_reg;
      end
      ST_LOAD: begin
        Mem_We    = load_wr;
        Mem_Addr  = load_cnt_reg[ADDR_SIZE-1:0];
        Mem_Wdata = load_wr ? Load_Data : 32'd0;
      end
      default: begin
        Mem_We = 1'b0;
      end
    endcase
  end

  // Boot sequencer: CLEAR -> LOAD -> RUN, with reload looping back to CLEAR.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_reg      <= ST_CLEAR;
      clear_cnt_reg  <= '0;
      load_cnt_reg   <= '0;
      load_error_reg <= 1'b0;
      load_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clear_cnt_reg <= clear_cnt_reg + 1'b1;
          if (clear_cnt_reg == LAST_CLEAR_ADDR) begin
            state_reg    <= ST_LOAD;
            load_cnt_reg <= '0;
          end
        end
        ST_LOAD: begin
          if (load_xfer) begin
            if (load_room) begin
              load_cnt_reg <= load_cnt_reg + 1'b1;
            end else begin
              // Image overran the memory: word dropped, flag it.
              load_error_reg <= 1'b1;
            end
            if (Load_Last) begin
              state_reg      <= ST_RUN;
              load_count_reg <= load_count_next;
            end
          end
        end
        ST_RUN: begin
          if (Reload_Req) begin
            state_reg      <= ST_CLEAR;
            clear_cnt_reg  <= '0;
            load_cnt_reg   <= '0;
            load_error_reg <= 1'b0;
            load_count_reg <= '0;
          end
        end
        default: begin
          state_reg <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl with a 16-word memory. A behavioural memory is
// written by the DUT's port; expected contents, counts, error flags and fetch
// addresses come from a simple image model and plain arithmetic.
module tb_imem_boot_ctrl;

  localparam int MEM = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          reload_req;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic [31:0]   fetch_addr;
  logic          fetch_misalign;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          boot_done;
  logic          load_error;
  logic [AW:0]   load_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tb_mem [MEM];
  logic [31:0] img [32];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  exp_addr;
    logic        exp_mis;
  } fetch_vec_t;
  fetch_vec_t vecs [7];

  imem_boot_ctrl #(.DWIDTH(32), .MEM_SIZE(MEM)) dut (
    .Clk_Core      (clk),
    .Rst_Core      (rst),
    .Reload_Req    (reload_req),
    .Load_Valid    (load_valid),
    .Load_Data     (load_data),
    .Load_Last     (load_last),
    .Load_Ready    (load_ready),
    .Fetch_Addr    (fetch_addr),
    .Fetch_Misalign(fetch_misalign),
    .Mem_Addr      (mem_addr),
    .Mem_We        (mem_we),
    .Mem_Wdata     (mem_wdata),
    .Core_Hold     (core_hold),
    .Boot_Done     (boot_done),
    .Load_Error    (load_error),
    .Load_Count    (load_count)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory driven by the DUT's port.
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts in the first CLEAR cycle; checks the 16 zero writes.
  task automatic run_clear(input bit hold_loader);
    for (int i = 0; i < MEM; i++) begin
      load_valid = hold_loader;
      load_data  = 32'hDEADBEEF;
      reload_req = (i == 5);
      @(negedge clk);
      chk("clr_we", mem_we, 1'b1);
      chk("clr_addr", mem_addr, i);
      chk("clr_wdata", mem_wdata, 32'd0);
      chk("clr_ready", load_ready, 1'b0);
      chk("clr_hold", core_hold, 1'b1);
      if (i == 0) begin
        chk("clr_done", boot_done, 1'b0);
        chk("clr_err", load_error, 1'b0);
        chk("clr_cnt", load_count, 0);
      end
      next_cycle();
    end
    load_valid = 1'b0;
    reload_req = 1'b0;
    $display("[TB] clear pass complete");
  endtask

  // Streams img[0..n-1]; gap<0 means exactly one idle cycle before each word,
  // otherwise 0..gap random idle cycles.
  task automatic load_image(input int n, input int gap, input bit reload_poke);
    int gaps;
    int exp_cnt;
    for (int k = 0; k < n; k++) begin
      gaps = (gap < 0) ? 1 : int'($urandom_range(0, gap));
      if (reload_poke && k == 1 && gaps == 0) gaps = 1;
      for (int g = 0; g < gaps; g++) begin
        load_valid = 1'b0;
        load_last  = 1'b1;
        reload_req = reload_poke && (k == 1) && (g == 0);
        @(negedge clk);
        chk("idle_ready", load_ready, 1'b1);
        chk("idle_we", mem_we, 1'b0);
        chk("idle_hold", core_hold, 1'b1);
        next_cycle();
      end
      reload_req = 1'b0;
      load_valid = 1'b1;
      load_data  = img[k];
      load_last  = (k == n - 1);
      @(negedge clk);
      chk("ld_ready", load_ready, 1'b1);
      chk("ld_we", mem_we, k < MEM);
      if (k < MEM) begin
        chk("ld_addr", mem_addr, k);
        chk("ld_wdata", mem_wdata, img[k]);
      end
      chk("ld_err_timing", load_error, k >= MEM + 1);
      next_cycle();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = $urandom;
    exp_cnt = (n < MEM) ? n : MEM;
    @(negedge clk);
    chk("run_done", boot_done, 1'b1);
    chk("run_hold", core_hold, 1'b0);
    chk("run_ready", load_ready, 1'b0);
    chk("run_count", load_count, exp_cnt);
    chk("run_err", load_error, n > MEM);
    for (int i = 0; i < MEM; i++) begin
      chk("mem_content", tb_mem[i], (i < n) ? img[i] : 32'd0);
    end
    $display("[TB] loaded %0d words, count=%0d err=%0b", n, load_count, load_error);
    next_cycle();
  endtask

  task automatic check_fetch(input logic [31:0] a, input logic [3:0] exp_a, input logic exp_m);
    fetch_addr = a;
    load_valid = 1'b1;
    @(negedge clk);
    chk("fetch_addr", mem_addr, exp_a);
    chk("fetch_mis", fetch_misalign, exp_m);
    chk("fetch_we", mem_we, 1'b0);
    chk("fetch_ready", load_ready, 1'b0);
    $display("[TB] fetch pc=0x%08h -> word %0d misalign=%0b", a, mem_addr, fetch_misalign);
    next_cycle();
    load_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload_req = 1'b1;
    @(negedge clk);
    chk("pre_reload_hold", core_hold, 1'b0);
    next_cycle();
    reload_req = 1'b0;
    $display("[TB] reload requested");
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst        = 1'b1;
    reload_req = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'd0;
    load_last  = 1'b0;
    fetch_addr = 32'h3;

    vecs[0] = '{32'h0000_0008, 4'd2,  1'b0};
    vecs[1] = '{32'h0000_0046, 4'd1,  1'b1};
    vecs[2] = '{32'h0000_0000, 4'd0,  1'b0};
    vecs[3] = '{32'h0000_003C, 4'd15, 1'b0};
    vecs[4] = '{32'h0000_0040, 4'd0,  1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 4'd15, 1'b1};
    vecs[6] = '{32'h1234_5613, 4'd4,  1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", core_hold, 1'b1);
    chk("rst_done", boot_done, 1'b0);
    chk("rst_ready", load_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_mis", fetch_misalign, 1'b0);
    chk("rst_err", load_error, 1'b0);
    chk("rst_cnt", load_count, 0);
    next_cycle();
    rst = 1'b0;

    // Clear with loader presenting words and a stray reload (both ignored)
    run_clear(1'b1);

    // Directed 4-word image, gapped, reload poked during LOAD
    img[0] = 32'h00500093; img[1] = 32'h00A00113;
    img[2] = 32'h002081B3; img[3] = 32'h0000006F;
    load_image(4, -1, 1'b1);

    for (int v = 0; v < 7; v++) check_fetch(vecs[v].addr, vecs[v].exp_addr, vecs[v].exp_mis);

    // Overflow image: 18 words into 16
    do_reload();
    run_clear(1'b0);
    for (int k = 0; k < 18; k++) img[k] = 32'h1000_0000 + k;
    load_image(18, 0, 1'b0);

    // Randomized images and fetches against the model
    for (int t = 0; t < 6; t++) begin
      do_reload();
      run_clear(t[0]);
      n = int'($urandom_range(1, 20));
      for (int k = 0; k < n; k++) img[k] = $urandom;
      load_image(n, 2, t[1]);
      for (int f = 0; f < 4; f++) begin
        a = $urandom;
        check_fetch(a, 4'((a / 4) % MEM), (a % 4) != 0);
      end
    end

    // Asynchronous reset in the middle of a load
    do_reload();
    run_clear(1'b0);
    for (int k = 0; k < 2; k++) begin
      load_valid = 1'b1;
      load_data  = 32'hA000_0000 + k;
      load_last  = 1'b0;
      next_cycle();
    end
    load_data = 32'hA000_0002;
    #1;
    rst = 1'b1;
    #2;
    chk("arst_ready", load_ready, 1'b0);
    chk("arst_we", mem_we, 1'b0);
    chk("arst_hold", core_hold, 1'b1);
    chk("arst_done", boot_done, 1'b0);
    chk("arst_cnt", load_count, 0);
    $display("[TB] async reset asserted mid-load");
    load_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    run_clear(1'b0);
    img[0] = 32'hCAFE_F00D;
    load_image(1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
